// File: rtl/vga_timing_defs.sv
// Shared timing defaults, counter/address widths and the registered pixel record
// for the 640x480@60Hz VGA signal generator.
package vga_timing_defs;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  // Both counters are 10 bits wide so the address slices below always exist.
  localparam int CNT_W     = 10;
  localparam int FB_X_W    = 8;
  localparam int FB_Y_W    = 7;
  localparam int FB_ADDR_W = FB_Y_W + FB_X_W;
  localparam int COLOUR_W  = 8;

  typedef struct packed {
    logic                hs;
    logic                vs;
    logic [COLOUR_W-1:0] colour;
  } vga_pix_t;

  localparam vga_pix_t PIX_RESET = '{hs: 1'b1, vs: 1'b1, colour: '0};

  function automatic logic in_window(input logic [CNT_W-1:0] count,
                                     input int first, input int last);
    return (int'(count) >= first) && (int'(count) <= last);
  endfunction

endpackage

// File: rtl/vga_sig_gen_if.sv
// Frame-buffer read port, colour configuration and VGA pin bundle.
// master = signal generator side, slave = frame buffer / board side.
interface vga_sig_gen_if;
  import vga_timing_defs::*;

  logic [2*COLOUR_W-1:0] config_colours;
  logic [FB_ADDR_W-1:0]  vga_addr;
  logic                  vga_data;
  logic                  vga_hs;
  logic                  vga_vs;
  logic [COLOUR_W-1:0]   vga_colour;
  logic                  frame_start;

  modport master (
    input  config_colours,
    input  vga_data,
    output vga_addr,
    output vga_hs,
    output vga_vs,
    output vga_colour,
    output frame_start
  );

  modport slave (
    output config_colours,
    output vga_data,
    input  vga_addr,
    input  vga_hs,
    input  vga_vs,
    input  vga_colour,
    input  frame_start
  );

endinterface

// File: rtl/vga_counter.sv
// Modulo-N counter with enable; wrap pulses in the enabled cycle that returns
// the count to zero.
module vga_counter
  import vga_timing_defs::*;
#(
  parameter int N = 800
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_sig_gen.sv
// VGA timing generator and 1-bit frame buffer reader: one pixel every CLK_DIV
// clocks, outputs registered one pixel period behind the counters.
module vga_sig_gen
  import vga_timing_defs::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic          clk,
  input  logic          resetn,
  vga_sig_gen_if.master vga
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             h_wrap;
  logic             v_en;
  logic             v_wrap;
  logic             at_origin;
  logic             visible;
  vga_pix_t         pix_next;
  vga_pix_t         pix_q;
  logic             frame_start_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign tick = (div == DIV_LAST);
  assign v_en = tick & h_wrap;

  vga_counter #(.N(H_TOTAL)) u_h_counter (
    .clk    (clk),
    .resetn (resetn),
    .en     (tick),
    .count  (h_count),
    .wrap   (h_wrap)
  );

  vga_counter #(.N(V_TOTAL)) u_v_counter (
    .clk    (clk),
    .resetn (resetn),
    .en     (v_en),
    .count  (v_count),
    .wrap   (v_wrap)
  );

  // Set while the counters sit on (0,0); avoids a full compare of both counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      at_origin <= 1'b1;
    end else if (tick) begin
      at_origin <= v_wrap;
    end
  end

  assign vga.vga_addr = {v_count[FB_Y_W+1:2], h_count[FB_X_W+1:2]};

  always_comb begin
    visible         = (int'(h_count) < H_VISIBLE) && (int'(v_count) < V_VISIBLE);
    pix_next.hs     = !in_window(h_count, HS_START, HS_END);
    pix_next.vs     = !in_window(v_count, VS_START, VS_END);
    pix_next.colour = '0;
    if (visible) begin
      pix_next.colour = vga.vga_data ? vga.config_colours[2*COLOUR_W-1:COLOUR_W]
                                     : vga.config_colours[COLOUR_W-1:0];
    end
  end

  // frame_start is a one-clock pulse, so it is reloaded every cycle, not only on tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_q         <= PIX_RESET;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick & at_origin;
      if (tick) begin
        pix_q <= pix_next;
      end
    end
  end

  assign vga.vga_hs      = pix_q.hs;
  assign vga.vga_vs      = pix_q.vs;
  assign vga.vga_colour  = pix_q.colour;
  assign vga.frame_start = frame_start_q;

endmodule
